// File: rtl/reg_rename_file_pkg.sv
// ============================================================================
// reg_rename_file_pkg : shared widths and tag constants for the rename file
// Revision 1.0
// ============================================================================
`default_nettype none

package reg_rename_file_pkg;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = 5;
  localparam int TAG_W = 4;
  localparam logic [TAG_W-1:0] TAG_NONE = '0;
endpackage

`default_nettype wire

// File: rtl/reg_rename_lookup.sv
// ============================================================================
// reg_rename_lookup : one source-operand read port with commit bypass
// Revision 1.0
// ============================================================================
`default_nettype none

module reg_rename_lookup
  import reg_rename_file_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int TAG_W = 4
) (
  input  logic [REG_W-1:0] i_addr,
  input  logic             i_busy,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [XLEN-1:0]  i_data,
  input  logic             i_cmt_valid,
  input  logic [REG_W-1:0] i_cmt_rd,
  input  logic [TAG_W-1:0] i_cmt_tag,
  input  logic [XLEN-1:0]  i_cmt_data,
  output logic [XLEN-1:0]  o_val,
  output logic [TAG_W-1:0] o_tag
);

  always_comb begin
    o_val = '0;
    o_tag = TAG_W'(TAG_NONE);
    if (i_addr == '0) begin
      o_val = '0;
    end else if (i_busy && i_cmt_valid && (i_cmt_rd == i_addr) && (i_cmt_tag == i_tag)) begin
      // The producer is retiring right now: forward its result.
      o_val = i_cmt_data;
    end else if (i_busy) begin
      o_tag = i_tag;
    end else begin
      o_val = i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_rename_file.sv
// ============================================================================
// reg_rename_file : architectural register file with rename status table
// Revision 1.0
// ============================================================================
`default_nettype none

module reg_rename_file #(
  parameter int XLEN  = reg_rename_file_pkg::XLEN,
  parameter int NREG  = reg_rename_file_pkg::NREG,
  parameter int REG_W = reg_rename_file_pkg::REG_W,
  parameter int TAG_W = reg_rename_file_pkg::TAG_W,
  parameter int NSRC  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  ren_valid,
  input  logic [REG_W-1:0]      ren_rd,
  input  logic [TAG_W-1:0]      ren_tag,
  input  logic [NSRC*REG_W-1:0] src_addr,
  output logic [NSRC*XLEN-1:0]  src_val,
  output logic [NSRC*TAG_W-1:0] src_tag,
  input  logic                  cmt_valid,
  input  logic [REG_W-1:0]      cmt_rd,
  input  logic [TAG_W-1:0]      cmt_tag,
  input  logic [XLEN-1:0]       cmt_data,
  input  logic                  flush,
  output logic [REG_W:0]        busy_cnt
);
  import reg_rename_file_pkg::*;

  localparam int CNT_W = REG_W + 1;

  logic [XLEN-1:0]  r_data [NREG];
  logic [TAG_W-1:0] r_tag  [NREG];
  logic [NREG-1:0]  r_busy;
  logic [CNT_W-1:0] r_busy_cnt;

  logic             w_cmt_wr;
  logic             w_clr;
  logic             w_ren;
  logic             w_inc;
  logic             w_dec;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_cmt_wr = cmt_valid && (cmt_rd != '0);
  assign w_clr    = w_cmt_wr && r_busy[cmt_rd] && (r_tag[cmt_rd] == cmt_tag);
  assign w_ren    = ren_valid && (ren_rd != '0) && !flush;
  // A clear cancelled by a same-register rename leaves the count untouched.
  assign w_inc    = w_ren && !r_busy[ren_rd];
  assign w_dec    = w_clr && !(w_ren && (ren_rd == cmt_rd));

  always_comb begin
    w_cnt_next = r_busy_cnt;
    if (w_inc && !w_dec) begin
      w_cnt_next = r_busy_cnt + CNT_W'(1);
    end else if (w_dec && !w_inc) begin
      w_cnt_next = r_busy_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= TAG_W'(TAG_NONE);
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else if (rdy) begin
      if (w_cmt_wr) begin
        r_data[cmt_rd] <= cmt_data;
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) begin
          r_tag[i] <= TAG_W'(TAG_NONE);
        end
        r_busy     <= '0;
        r_busy_cnt <= '0;
      end else begin
        if (w_clr) begin
          r_busy[cmt_rd] <= 1'b0;
          r_tag[cmt_rd]  <= TAG_W'(TAG_NONE);
        end
        // Rename follows the clear so it wins on the same register.
        if (w_ren) begin
          r_busy[ren_rd] <= 1'b1;
          r_tag[ren_rd]  <= ren_tag;
        end
        r_busy_cnt <= w_cnt_next;
      end
    end
  end

  assign busy_cnt = r_busy_cnt;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [REG_W-1:0] w_addr;
    assign w_addr = src_addr[k*REG_W +: REG_W];

    reg_rename_lookup #(
      .XLEN  (XLEN),
      .REG_W (REG_W),
      .TAG_W (TAG_W)
    ) u_lookup (
      .i_addr      (w_addr),
      .i_busy      (r_busy[w_addr]),
      .i_tag       (r_tag[w_addr]),
      .i_data      (r_data[w_addr]),
      .i_cmt_valid (cmt_valid),
      .i_cmt_rd    (cmt_rd),
      .i_cmt_tag   (cmt_tag),
      .i_cmt_data  (cmt_data),
      .o_val       (src_val[k*XLEN +: XLEN]),
      .o_tag       (src_tag[k*TAG_W +: TAG_W])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_rename_file.sv
// ============================================================================
// tb_reg_rename_file : directed self-checking bench for reg_rename_file
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_reg_rename_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        ren_valid;
  logic [4:0]  ren_rd;
  logic [3:0]  ren_tag;
  logic [9:0]  src_addr;
  logic [63:0] src_val;
  logic [7:0]  src_tag;
  logic        cmt_valid;
  logic [4:0]  cmt_rd;
  logic [3:0]  cmt_tag;
  logic [31:0] cmt_data;
  logic        flush;
  logic [5:0]  busy_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  reg_rename_file dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .ren_valid (ren_valid),
    .ren_rd    (ren_rd),
    .ren_tag   (ren_tag),
    .src_addr  (src_addr),
    .src_val   (src_val),
    .src_tag   (src_tag),
    .cmt_valid (cmt_valid),
    .cmt_rd    (cmt_rd),
    .cmt_tag   (cmt_tag),
    .cmt_data  (cmt_data),
    .flush     (flush),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren_valid = 1'b0;
    cmt_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] tag);
    ren_valid = 1'b1;
    ren_rd    = rd;
    ren_tag   = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] data);
    cmt_valid = 1'b1;
    cmt_rd    = rd;
    cmt_tag   = tag;
    cmt_data  = data;
  endtask

  task automatic srcs(input logic [4:0] a0, input logic [4:0] a1);
    src_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    ren_valid = 1'b0; ren_rd = '0; ren_tag = '0;
    cmt_valid = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_data = '0;
    src_addr = '0;
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    srcs(5'd5, 5'd31);
    check("rst_val0", src_val[31:0], 0);
    check("rst_tag0", src_tag[3:0], 0);
    check("rst_val1", src_val[63:32], 0);
    check("rst_tag1", src_tag[7:4], 0);
    check("rst_cnt", busy_cnt, 0);

    // Rename then commit with same-cycle bypass
    rename(5'd5, 4'd3); tick(); idle();
    check("ren_tag_x5", src_tag[3:0], 3);
    check("ren_cnt_x5", busy_cnt, 1);
    commit(5'd5, 4'd3, 32'hDEADBEEF); #1;
    check("byp_val_x5", src_val[31:0], 32'hDEADBEEF);
    check("byp_tag_x5", src_tag[3:0], 0);
    tick(); idle(); #1;
    check("cmt_val_x5", src_val[31:0], 32'hDEADBEEF);
    check("cmt_tag_x5", src_tag[3:0], 0);
    check("cmt_cnt_x5", busy_cnt, 0);

    // Stale commit keeps the newer producer
    srcs(5'd7, 5'd31);
    rename(5'd7, 4'd2); tick();
    rename(5'd7, 4'd5); tick(); idle();
    check("rr_tag_x7", src_tag[3:0], 5);
    check("rr_cnt_x7", busy_cnt, 1);
    commit(5'd7, 4'd2, 32'h11); #1;
    check("stale_byp_tag", src_tag[3:0], 5);
    check("stale_byp_val", src_val[31:0], 0);
    tick(); idle(); #1;
    check("stale_tag_x7", src_tag[3:0], 5);
    check("stale_cnt", busy_cnt, 1);
    commit(5'd7, 4'd5, 32'h22); tick(); idle(); #1;
    check("fresh_val_x7", src_val[31:0], 32'h22);
    check("fresh_tag_x7", src_tag[3:0], 0);
    check("fresh_cnt", busy_cnt, 0);

    // Simultaneous commit and rename of the same register
    srcs(5'd9, 5'd31);
    rename(5'd9, 4'd4); tick(); idle();
    commit(5'd9, 4'd4, 32'h55); rename(5'd9, 4'd6); tick(); idle(); #1;
    check("sim_tag_x9", src_tag[3:0], 6);
    check("sim_cnt", busy_cnt, 1);
    flush = 1'b1; tick(); idle(); #1;
    check("sim_data_x9", src_val[31:0], 32'h55);
    check("sim_flush_cnt", busy_cnt, 0);

    // x0 protection and self-dependency
    commit(5'd3, 4'd1, 32'h33); tick(); idle();
    srcs(5'd0, 5'd3);
    rename(5'd0, 4'd1); tick(); idle(); #1;
    check("x0_val", src_val[31:0], 0);
    check("x0_tag", src_tag[3:0], 0);
    check("x0_cnt", busy_cnt, 0);
    rename(5'd3, 4'd2); #1;
    check("self_val_x3", src_val[63:32], 32'h33);
    check("self_tag_x3", src_tag[7:4], 0);
    tick(); idle(); #1;
    check("self_next_tag", src_tag[7:4], 2);
    check("self_next_cnt", busy_cnt, 1);

    // Flush with same-cycle commit and rename
    rename(5'd1, 4'd1); tick();
    rename(5'd2, 4'd4); tick(); idle(); #1;
    check("pre_flush_cnt", busy_cnt, 3);
    flush = 1'b1; commit(5'd4, 4'd1, 32'h77); rename(5'd6, 4'd7); tick(); idle();
    srcs(5'd4, 5'd6);
    check("flush_cnt", busy_cnt, 0);
    check("flush_val_x4", src_val[31:0], 32'h77);
    check("flush_tag_x6", src_tag[7:4], 0);
    srcs(5'd3, 5'd2);
    check("flush_tag_x3", src_tag[3:0], 0);
    check("flush_val_x3", src_val[31:0], 32'h33);
    check("flush_tag_x2", src_tag[7:4], 0);

    // Stall holds all state
    rdy = 1'b0; rename(5'd8, 4'd3); commit(5'd10, 4'd1, 32'hAA); tick(); idle(); rdy = 1'b1;
    srcs(5'd8, 5'd10);
    check("stall_cnt", busy_cnt, 0);
    check("stall_tag_x8", src_tag[3:0], 0);
    check("stall_val_x10", src_val[63:32], 0);
    rename(5'd8, 4'd3); tick(); idle(); #1;
    check("post_stall_tag", src_tag[3:0], 3);
    check("post_stall_cnt", busy_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Parametrised architectural register file plus rename status table for the Tomasulo core.
- Holds committed values, a per-register busy bit and the ROB tag of the newest in-flight producer.
- Serves NSRC source-operand lookups per cycle for the issue stage, accepts one rename (rd allocation) and one ROB commit per cycle, and supports branch flush.
- Adds over the previous generation: configurable source-port count, commit-to-lookup bypass, x0 protection, correct same-cycle rename/commit ordering, and a live busy-register counter.

Parameters:
XLEN, 32, data width
NREG, 32, architectural register count (power of 2)
REG_W, 5, log2(NREG)
TAG_W, 4, ROB tag width; tag value 0 is reserved as "no producer"
NSRC, 2, number of source lookup ports

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
rdy  in  1  ready; state holds when low
ren_valid  in  1  rename request this cycle
ren_rd  in  REG_W  destination register being allocated
ren_tag  in  TAG_W  ROB tag allocated to ren_rd (never 0)
src_addr  in  NSRC*REG_W  flattened source register indices, port k at [k*REG_W +: REG_W]
src_val  out  NSRC*XLEN  operand value (valid when src_tag==0)
src_tag  out  NSRC*TAG_W  producer tag; 0 = value ready
cmt_valid  in  1  ROB head commits this cycle
cmt_rd  in  REG_W  committed destination
cmt_tag  in  TAG_W  ROB tag of committing entry
cmt_data  in  XLEN  committed result
flush  in  1  mispredict flush: drop all renames
busy_cnt  out  REG_W+1  number of currently busy registers (registered)

Behaviour:
- Reset (sampled at posedge with rst==0, overrides everything): all data=0, busy=0, tag=0, busy_cnt=0. Consequently every src_tag=0 and src_val=0 after reset.
- rdy==0 and rst==1: no state change. Lookups remain combinational on held state.
- Lookup (combinational, each port k independently; reflects state before this cycle's rename, so an instruction never depends on itself):
  - src_addr==0 -> val 0, tag 0.
  - else busy && cmt_valid && cmt_rd==src_addr && cmt_tag==tag[src] -> val=cmt_data, tag 0 (commit bypass).
  - else busy -> val 0, tag=tag[src].
  - else val=data[src], tag 0.
- Commit (posedge, rdy, no flush required):
  - If cmt_valid && cmt_rd!=0, data[cmt_rd]<=cmt_data unconditionally.
  - If additionally busy[cmt_rd] && tag[cmt_rd]==cmt_tag, clear busy and tag to 0.
  - A tag mismatch means a newer producer exists; busy and tag are kept.
- Rename (posedge, rdy, flush==0): if ren_valid && ren_rd!=0, busy[ren_rd]<=1 and tag[ren_rd]<=ren_tag. ren_rd==0 is ignored.
- Same rd renamed and committed in one cycle: data is written, busy stays 1, tag=ren_tag. Rename wins over the clear.
- Flush (posedge, rdy): all busy=0, tags=0, busy_cnt=0; rename is ignored; a same-cycle commit data write still occurs. Data is otherwise retained.
- busy_cnt: after every edge equals popcount(busy). It is updated incrementally:
  - +1 for a rename of a non-busy register that is not also being cleared.
  - -1 for a clear not cancelled by a same-register rename.
  - 0 for re-renaming an already busy register.
  - It can never exceed NREG-1 (x0 is never busy).
- Latency: a lookup sees a rename one cycle later; it sees a commit in the same cycle via the bypass.

Decomposition:
- Shared package/def header: XLEN, NREG, REG_W, TAG_W, and TAG_NONE=0 constants.
- Natural sub-module: reg_rename_lookup, one combinational port instance per NSRC, implementing the 4-way lookup priority.
- State arrays and the counter stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release; read x5, x31 -> val 0, tag 0; busy_cnt=0.
- Rename then commit: rename x5 tag 3. Next cycle x5 lookup -> tag 3. Commit x5/tag3/0xDEADBEEF: same cycle lookup -> val 0xDEADBEEF, tag 0. Next cycle -> data 0xDEADBEEF, busy_cnt 0.
- Stale commit: rename x7 tag 2, then x7 tag 5; commit x7 tag 2 data 0x11 -> x7 still tag 5, busy_cnt=1. Commit tag 5 data 0x22 -> x7 ready, val 0x22.
- Simultaneous: x9 busy tag 4. In one cycle commit x9 tag 4 data 0x55 and rename x9 tag 6 -> next cycle x9 tag 6, data[x9]=0x55 (visible after tag 6 commits with its own value), busy_cnt unchanged at 1.
- x0 and self-dependency: rename x0 tag 1 -> x0 lookup val 0 tag 0, busy_cnt 0. Same cycle, rename x3 tag 2 while src_addr=x3 (not busy) -> lookup returns old data, tag 0.
- Flush and stall: rename x1, x2, x3 (busy_cnt 3); assert flush with commit x4 data 0x77 and rename x6 -> all tags 0, busy_cnt 0, x4=0x77, x6 not busy. With rdy=0, a rename of x8 leaves busy_cnt and x8 unchanged.
